// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches over a valid/ready imem handshake and
// holds each instruction stable for the control unit until the core acks it.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    input  logic            inst_ack,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_inst_valid;
    logic            r_fault;
    logic            w_misaligned;

    assign w_misaligned   = redirect_pc[1:0] != 2'b00;
    assign imem_req_valid = r_state == S_REQ;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    // Bubbles decode as all-zero so the control unit raises no enables.
    assign opcode         = r_inst_valid ? r_inst[6:0] : 7'b0000000;
    assign fetch_fault    = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: if (imem_req_ready) r_state <= S_WAIT;
                S_WAIT: if (imem_resp_valid) begin
                    r_inst       <= imem_resp_data;
                    r_inst_pc    <= r_pc;
                    r_inst_valid <= 1'b1;
                    r_state      <= S_HOLD;
                end
                S_HOLD: if (inst_ack) begin
                    r_inst_valid <= 1'b0;
                    if (!redirect_valid) begin
                        r_pc    <= r_pc + XLEN'(4);
                        r_state <= S_REQ;
                    end else if (w_misaligned) begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_pc    <= redirect_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_fault <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random imem/core stimulus with a queue scoreboard of
// expected fetch addresses and delivered instructions.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        inst_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
        .inst_ack(inst_ack), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; int due; } rsp_t;

    req_t        exp_req[$];
    rsp_t        exp_rsp[$];
    rsp_t        cur;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          n_inst = 0;
    logic        model_fault = 1'b0;
    logic [31:0] model_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: imem model, core model and the architectural PC model.
    initial begin
        int          rst_cnt, wcnt, fault_cyc, sel;
        logic        waiting;
        logic [31:0] acc_pc, rnd;
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        inst_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_pc = RESET_PC; waiting = 1'b0; wcnt = 0; fault_cyc = 0; acc_pc = '0;
        rst_cnt = 1;
        for (int n = 0; n < 8000; n++) begin
            @(negedge clk); #1;
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            inst_ack        = 1'b0;
            redirect_valid  = 1'($urandom_range(0, 1));
            redirect_pc     = $urandom;
            imem_req_ready  = $urandom_range(0, 3) != 0;
            if (model_fault) fault_cyc++;
            if (rst_cnt == 0 && (fault_cyc > 4 || $urandom_range(0, 199) == 0))
                rst_cnt = $urandom_range(1, 2);
            if (rst_cnt > 0) begin
                reset = 1'b1;
                rst_cnt--;
                model_pc = RESET_PC; waiting = 1'b0; model_fault = 1'b0; fault_cyc = 0;
            end else begin
                reset = 1'b0;
                if (waiting) begin
                    wcnt--;
                    if (wcnt == 0) begin
                        imem_resp_valid = 1'b1;
                        exp_rsp.push_back('{acc_pc, imem_resp_data, cyc + 1});
                        waiting = 1'b0;
                    end
                end else if (imem_req_valid && imem_req_ready) begin
                    waiting = 1'b1;
                    wcnt    = $urandom_range(1, 3);
                    acc_pc  = model_pc;
                end else if ($urandom_range(0, 2) == 0) begin
                    imem_resp_valid = 1'b1;
                end
                if (inst_valid && $urandom_range(0, 1) == 0) begin
                    inst_ack = 1'b1;
                    sel = $urandom_range(0, 19);
                    rnd = $urandom;
                    redirect_valid = sel < 5;
                    if (sel < 2) redirect_pc = {rnd[31:2], 2'b00};
                    else if (sel == 2) redirect_pc = 32'hFFFF_FFFC;
                    else if (sel == 3) redirect_pc = 32'h0000_0100;
                    else if (sel == 4) redirect_pc = {rnd[31:2], 2'($urandom_range(1, 3))};
                    if (!redirect_valid) model_pc = model_pc + 32'd4;
                    else if (redirect_pc % 4 != 0) model_fault = 1'b1;
                    else model_pc = redirect_pc;
                    if (!model_fault) exp_req.push_back('{model_pc, cyc + 1});
                end else if (!inst_valid && $urandom_range(0, 3) == 0) begin
                    inst_ack = 1'b1;
                end
            end
        end
        @(negedge clk); #3;
        chk("retired_min", 32'(n_inst >= 200), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: sees outputs for the current cycle and inputs for the next edge.
    initial begin
        logic rst_prev, held, prev_req, prev_fault;
        rst_prev = 1'b1; held = 1'b0; prev_req = 1'b0; prev_fault = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst_prev) begin
                exp_req.delete();
                exp_rsp.delete();
                exp_req.push_back('{RESET_PC, -1});
                chk("rst_inst", inst, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
                chk("rst_inst_valid", 32'(inst_valid), 32'd0);
                chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
            end
            chk("fetch_fault", 32'(fetch_fault), 32'(prev_fault));
            if (inst_valid && !held) begin
                if (exp_rsp.size() == 0) chk("unexpected_inst", 32'(inst_valid), 32'd0);
                else begin
                    cur = exp_rsp.pop_front();
                    n_inst++;
                    held = 1'b1;
                    chk("inst", inst, cur.data);
                    chk("inst_pc", inst_pc, cur.pc);
                    chk("opcode", 32'(opcode), 32'(cur.data[6:0]));
                    chk("inst_latency", 32'(cyc), 32'(cur.due));
                end
            end else if (inst_valid) begin
                chk("inst_stable", inst, cur.data);
                chk("opcode_stable", 32'(opcode), 32'(cur.data[6:0]));
            end else begin
                held = 1'b0;
                chk("opcode_bubble", 32'(opcode), 32'd0);
            end
            if (imem_req_valid) begin
                if (exp_req.size() == 0) chk("unexpected_req", 32'(imem_req_valid), 32'd0);
                else begin
                    chk("req_addr", imem_req_addr, exp_req[0].addr);
                    if (!prev_req && exp_req[0].due >= 0)
                        chk("req_latency", 32'(cyc), 32'(exp_req[0].due));
                    if (imem_req_ready && !reset) exp_req.delete(0);
                end
            end
            prev_req   = imem_req_valid;
            rst_prev   = reset;
            prev_fault = model_fault;
        end
    end
endmodule
